// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - show-ahead instruction queue between I-cache fetch and decode
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_instr,
    input  logic             if_adel,
    output logic             if_ready,
    input  logic             stallD,
    output logic             validD,
    output logic [31:0]      instrD,
    output logic [31:0]      pcD,
    output logic             adelD,
    output logic [PTR_W:0]   countQ
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic             adel_mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    // if_ready looks only at the registered count, so a full queue refuses
    // an offer even in a cycle where decode drains the head.
    assign if_ready = (count != FULL_CNT);
    assign validD   = (count != '0);
    assign push     = if_valid & if_ready;
    assign pop      = validD & ~stallD;

    assign pcD    = pc_mem[rd_ptr];
    assign instrD = validD ? instr_mem[rd_ptr] : 32'h0;
    assign adelD  = validD & adel_mem[rd_ptr];
    assign countQ = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Only slot 0 is cleared on reset: it is the head after reset, which keeps pcD defined.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_mem[0] <= '0;
        end else if (push && !flush) begin
            pc_mem[wr_ptr]    <= if_pc;
            instr_mem[wr_ptr] <= if_instr;
            adel_mem[wr_ptr]  <= if_adel;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue against a queue model
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_adel;
    logic        if_ready;
    logic        stallD;
    logic        validD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        adelD;
    logic [2:0]  countQ;

    int n_vec = 0;
    int n_err = 0;

    // model entries packed as {adel, pc, instr}
    logic [64:0] mq[$];

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_adel(if_adel),
        .if_ready(if_ready), .stallD(stallD),
        .validD(validD), .instrD(instrD), .pcD(pcD), .adelD(adelD), .countQ(countQ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] p, input logic [31:0] i,
                        input logic a, input logic s);
        bit do_push, do_pop;
        @(negedge clk);
        rst = r; flush = f; if_valid = v; if_pc = p; if_instr = i; if_adel = a; stallD = s;
        #1;
        check("countQ",   32'(countQ),   32'(mq.size()));
        check("validD",   32'(validD),   32'(mq.size() != 0));
        check("if_ready", 32'(if_ready), 32'(mq.size() != 4));
        if (mq.size() != 0) begin
            check("instrD", instrD,       mq[0][31:0]);
            check("pcD",    pcD,          mq[0][63:32]);
            check("adelD",  32'(adelD),   32'(mq[0][64]));
        end else begin
            check("instrD_empty", instrD,     32'h0);
            check("adelD_empty",  32'(adelD), 32'h0);
        end
        if (r || f) begin
            mq.delete();
        end else begin
            do_push = v && (mq.size() < 4);
            do_pop  = (mq.size() != 0) && !s;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({a, p, i});
        end
    endtask

    task automatic idle(input logic s);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, s);
    endtask

    task automatic offer(input logic [31:0] p, input logic a, input logic s);
        step(1'b0, 1'b0, 1'b1, p, 32'h24020000 | ((p - 32'hBFC00000) >> 2) + 32'h1, a, s);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0;
        if_adel = 1'b0; stallD = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // idle after reset
        idle(1'b0);
        idle(1'b0);

        // fill to full under stall, 5th offer ignored, then drain
        for (int k = 0; k < 4; k++) offer(32'hBFC00000 + 32'(4 * k), 1'b0, 1'b1);
        offer(32'hBFC00010, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) idle(1'b0);

        // full with simultaneous pop and offer: pop only, offer accepted next cycle
        for (int k = 0; k < 4; k++) offer(32'hBFC00020 + 32'(4 * k), 1'b0, 1'b1);
        offer(32'hBFC00030, 1'b0, 1'b0);
        offer(32'hBFC00030, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) idle(1'b0);

        // steady push+pop from count=2 across pointer wrap
        offer(32'hBFC00100, 1'b0, 1'b1);
        offer(32'hBFC00104, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) offer(32'hBFC00108 + 32'(4 * k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b0);

        // address-error entry between two clean neighbours
        offer(32'hBFC00000, 1'b0, 1'b1);
        offer(32'hBFC00002, 1'b1, 1'b1);
        offer(32'hBFC00004, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) idle(1'b0);

        // flush with a concurrent offer, then the same with reset
        for (int k = 0; k < 3; k++) offer(32'hBFC00200 + 32'(4 * k), 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'hBFC0020C, 32'h2402000D, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        for (int k = 0; k < 3; k++) offer(32'hBFC00300 + 32'(4 * k), 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'hBFC0030C, 32'h2402000E, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(99) < 1), ($urandom_range(99) < 3),
                 ($urandom_range(99) < 70), $urandom, $urandom,
                 ($urandom_range(99) < 15), ($urandom_range(99) < 40));
        end
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
